// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, the frame length and the parity function.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StData,
      StAck,
      StWaitIdle
   } ps2_state_e;

   // Data bits, parity and stop; the start bit is driven during request-to-send.
   localparam int unsigned FrameLen = 10;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer, stability filter and one-cycle falling-edge pulse
// for an asynchronous PS/2 line.
module ps2_sync_edge #(
   parameter int unsigned FILTER_CYC = 8
) (
   input  logic clk_i,
   input  logic res_n_i,
   input  logic line_i,
   output logic filt_o,
   output logic fe_o
);

   localparam int unsigned CntW = $clog2(FILTER_CYC) + 1;

   logic [1:0]      sync_q;
   logic            filt_q, filt_d;
   logic            fe_q, fe_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Any sample that matches the accepted level restarts the stability count.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      fe_d   = 1'b0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q >= CntW'(FILTER_CYC - 1)) begin
            filt_d = sync_q[1];
            fe_d   = filt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         fe_q   <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         filt_q <= filt_d;
         fe_q   <= fe_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;
   assign fe_o   = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts a
// byte with odd parity out on device clock falling edges and checks the ack.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC = 2400,
   parameter int unsigned TIMEOUT_CYC = 360000,
   parameter int unsigned FILTER_CYC  = 8
) (
   input  logic       clk_i,
   input  logic       res_n_i,
   input  logic [7:0] data_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o
);

   localparam int unsigned InhW = $clog2(INHIBIT_CYC) + 1;
   localparam int unsigned ToW  = $clog2(TIMEOUT_CYC) + 1;
   localparam int unsigned BitW = $clog2(FrameLen) + 1;

   ps2_state_e          state_q, state_d;
   logic [FrameLen-1:0] frame_q, frame_d;
   logic [BitW-1:0]     bit_q, bit_d;
   logic [InhW-1:0]     inh_q, inh_d, inh_inc;
   logic [ToW-1:0]      tout_q, tout_d, tout_inc;
   logic                dat_oe_q, dat_oe_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [1:0]          dat_sync_q;
   logic                dat_sync;
   logic                clk_filt, clk_fe;
   logic                inh_done, timeout;

   ps2_sync_edge #(
      .FILTER_CYC(FILTER_CYC)
   ) u_clk_sync (
      .clk_i  (clk_i),
      .res_n_i(res_n_i),
      .line_i (ps2_clk_i),
      .filt_o (clk_filt),
      .fe_o   (clk_fe)
   );

   assign dat_sync = dat_sync_q[1];

   // Both counters saturate instead of wrapping.
   assign inh_inc  = (inh_q == '1) ? inh_q : inh_q + 1'b1;
   assign tout_inc = (tout_q == '1) ? tout_q : tout_q + 1'b1;
   assign inh_done = (inh_inc == InhW'(INHIBIT_CYC));
   assign timeout  = (tout_inc == ToW'(TIMEOUT_CYC));

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state_q    <= StIdle;
         frame_q    <= '0;
         bit_q      <= '0;
         inh_q      <= '0;
         tout_q     <= '0;
         dat_oe_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         dat_sync_q <= 2'b11;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         bit_q      <= bit_d;
         inh_q      <= inh_d;
         tout_q     <= tout_d;
         dat_oe_q   <= dat_oe_d;
         done_q     <= done_d;
         error_q    <= error_d;
         dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      end
   end

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      bit_d    = bit_q;
      inh_d    = inh_q;
      tout_d   = tout_q;
      dat_oe_d = dat_oe_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            dat_oe_d = 1'b0;
            if (start_i) begin
               frame_d = {1'b1, odd_parity(data_i), data_i};
               bit_d   = '0;
               inh_d   = '0;
               tout_d  = '0;
               state_d = StInhibit;
            end
         end
         StInhibit: begin
            inh_d = inh_inc;
            if (inh_done) begin
               dat_oe_d = 1'b1;
               state_d  = StRts;
            end
         end
         StRts: begin
            tout_d  = '0;
            state_d = StData;
         end
         StData, StAck, StWaitIdle: begin
            tout_d = tout_inc;
            // A timeout wins over an edge arriving in the same cycle.
            if (timeout) begin
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               state_d  = StIdle;
            end else if (state_q == StData) begin
               if (clk_fe) begin
                  dat_oe_d = ~frame_q[0];
                  frame_d  = frame_q >> 1;
                  bit_d    = bit_q + 1'b1;
                  if (bit_q == BitW'(FrameLen - 1)) begin
                     state_d = StAck;
                  end
               end
            end else if (state_q == StAck) begin
               if (clk_fe) begin
                  dat_oe_d = 1'b0;
                  if (dat_sync) begin
                     error_d = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StWaitIdle;
                  end
               end
            end else if (clk_filt && dat_sync) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o       = (state_q != StIdle);
      ps2_clk_oe_o = (state_q == StInhibit) || (state_q == StRts);
      ps2_dat_oe_o = dat_oe_q;
      done_o       = done_q;
      error_o      = error_q;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host and compares them against a scoreboard of expected frames.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       res_n;
   logic [7:0] data;
   logic       start;
   logic       busy, done, error, clk_oe, dat_oe;
   logic       ps2_clk, ps2_dat;
   logic       dev_clk_low, dev_dat_low, glitch_lo, glitch_hi;

   logic       to_start, to_busy, to_done, to_error, to_clk_oe, to_dat_oe;
   logic       to_clk, to_dat;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_done   = 0;
   int         n_err    = 0;
   int         n_xfer   = 0;
   int         inh_cnt  = 0;
   logic       clk_oe_prev = 1'b0;
   logic [9:0] bits;
   logic [9:0] sb_q[$];

   always #5 clk = ~clk;

   // Open-drain bus: any party pulling low wins; glitch_hi forces a short high spike.
   assign ps2_clk = glitch_hi ? 1'b1 : ~(clk_oe | dev_clk_low | glitch_lo);
   assign ps2_dat = ~(dat_oe | dev_dat_low);
   assign to_clk  = ~to_clk_oe;
   assign to_dat  = ~to_dat_oe;

   ps2_host_tx u_dut (
      .clk_i       (clk),
      .res_n_i     (res_n),
      .data_i      (data),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .error_o     (error),
      .ps2_clk_i   (ps2_clk),
      .ps2_dat_i   (ps2_dat),
      .ps2_clk_oe_o(clk_oe),
      .ps2_dat_oe_o(dat_oe)
   );

   ps2_host_tx #(
      .INHIBIT_CYC(50),
      .TIMEOUT_CYC(1000)
   ) u_dut_to (
      .clk_i       (clk),
      .res_n_i     (res_n),
      .data_i      (8'h5A),
      .start_i     (to_start),
      .busy_o      (to_busy),
      .done_o      (to_done),
      .error_o     (to_error),
      .ps2_clk_i   (to_clk),
      .ps2_dat_i   (to_dat),
      .ps2_clk_oe_o(to_clk_oe),
      .ps2_dat_oe_o(to_dat_oe)
   );

   always @(negedge clk) begin
      clk_oe_prev <= clk_oe;
      if (done) n_done <= n_done + 1;
      if (error) n_err <= n_err + 1;
      if (clk_oe && !dat_oe) inh_cnt <= inh_cnt + 1;
      if (clk_oe && !clk_oe_prev) n_xfer <= n_xfer + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] exp_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0), d};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      data  = d;
      start = 1'b1;
      sb_q.push_back(exp_frame(d));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic score(input logic [9:0] got);
      check("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) check("frame", 32'(got), 32'(sb_q.pop_front()));
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (busy && k < lim) begin
         @(negedge clk);
         k++;
      end
      check("busy_drop", 32'(busy), 32'd0);
   endtask

   // Device side: waits for request-to-send, then generates n_fe clock pulses,
   // sampling data on each rising edge; the 11th pulse carries the ack.
   task automatic dev_frame(input int half, input int n_fe, input bit ack, input bit glitchy,
                            output logic [9:0] got);
      int k = 0;
      got = '0;
      while (!(busy && !clk_oe && dat_oe) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("rts_seen", 32'(busy && !clk_oe && dat_oe), 32'd1);
      if (!(busy && !clk_oe && dat_oe)) return;
      cycles(half);
      for (int i = 1; i <= n_fe; i++) begin
         if (i == 11 && ack) begin
            dev_dat_low = 1'b1;
            cycles(20);
         end
         dev_clk_low = 1'b1;
         if (glitchy && i <= 10) begin
            cycles(half / 2);
            glitch_hi = 1'b1;
            cycles(3);
            glitch_hi = 1'b0;
            cycles(half - half / 2 - 3);
         end else begin
            cycles(half);
         end
         dev_clk_low = 1'b0;
         if (i <= 10) got[i-1] = ps2_dat;
         if (i == 11) begin
            cycles(20);
            dev_dat_low = 1'b0;
         end
         if (glitchy && i <= 10) begin
            cycles(half / 2);
            glitch_lo = 1'b1;
            cycles(3);
            glitch_lo = 1'b0;
            cycles(half - half / 2 - 3);
         end else begin
            cycles(half);
         end
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, e0, i0, x0, k;
      res_n       = 1'b0;
      data        = 8'h00;
      start       = 1'b0;
      to_start    = 1'b0;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      glitch_lo   = 1'b0;
      glitch_hi   = 1'b0;
      cycles(3);
      check("reset_outs", 32'({busy, done, error, clk_oe, dat_oe}), 32'd0);
      check("reset_outs_to", 32'({to_busy, to_done, to_error, to_clk_oe, to_dat_oe}), 32'd0);
      @(negedge clk);
      res_n = 1'b1;
      cycles(20);

      // 0xED at 12 kHz device clock.
      d0 = n_done; e0 = n_err; i0 = inh_cnt;
      send(8'hED);
      dev_frame(1000, 11, 1'b1, 1'b0, bits);
      score(bits);
      wait_idle(300);
      check("t1_inhibit_cycles", 32'(inh_cnt - i0), 32'd2400);
      check("t1_parity", 32'(bits[8]), 32'd1);
      check("t1_done_pulses", 32'(n_done - d0), 32'd1);
      check("t1_err_pulses", 32'(n_err - e0), 32'd0);

      // Back-to-back 0x07 / 0x00 with a stray start during the first transfer.
      d0 = n_done; x0 = n_xfer;
      send(8'h07);
      fork
         dev_frame(100, 11, 1'b1, 1'b0, bits);
         begin
            cycles(3000);
            data  = 8'h55;
            start = 1'b1;
            cycles(1);
            start = 1'b0;
         end
      join
      score(bits);
      check("t2_parity_07", 32'(bits[8]), 32'd0);
      wait_idle(300);
      send(8'h00);
      dev_frame(100, 11, 1'b1, 1'b0, bits);
      score(bits);
      check("t2_parity_00", 32'(bits[8]), 32'd1);
      wait_idle(300);
      cycles(500);
      check("t2_transfers", 32'(n_xfer - x0), 32'd2);
      check("t2_done_pulses", 32'(n_done - d0), 32'd2);
      check("t2_busy_after", 32'(busy), 32'd0);

      // Missing ack.
      d0 = n_done; e0 = n_err;
      send(8'hA5);
      dev_frame(100, 11, 1'b0, 1'b0, bits);
      score(bits);
      wait_idle(300);
      check("t3_err_pulses", 32'(n_err - e0), 32'd1);
      check("t3_done_pulses", 32'(n_done - d0), 32'd0);
      check("t3_lines", 32'({clk_oe, dat_oe}), 32'd0);

      // Silent device on the short-timeout instance.
      @(negedge clk);
      to_start = 1'b1;
      @(negedge clk);
      to_start = 1'b0;
      k = 0;
      while (!to_clk_oe && k < 100) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (to_clk_oe && k < 200) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (!to_error && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("t4_timeout_cycles", 32'(k), 32'd1000);
      check("t4_lines", 32'({to_clk_oe, to_dat_oe}), 32'd0);
      check("t4_busy", 32'(to_busy), 32'd0);
      cycles(1);
      check("t4_err_single", 32'(to_error), 32'd0);

      // Reset in the middle of data bit 4, then a clean 0xFF.
      send(8'hED);
      dev_frame(100, 5, 1'b0, 1'b0, bits);
      check("t5_dat_oe_bit4", 32'(dat_oe), 32'd1);
      #2;
      res_n = 1'b0;
      #1;
      check("t5_async_release", 32'({busy, clk_oe, dat_oe}), 32'd0);
      sb_q.delete();
      @(negedge clk);
      res_n = 1'b1;
      cycles(20);
      d0 = n_done;
      send(8'hFF);
      dev_frame(100, 11, 1'b1, 1'b0, bits);
      score(bits);
      wait_idle(300);
      check("t5_done_pulses", 32'(n_done - d0), 32'd1);

      // Short glitches on the clock pad in both phases.
      d0 = n_done; e0 = n_err;
      send(8'h3C);
      dev_frame(100, 11, 1'b1, 1'b1, bits);
      score(bits);
      wait_idle(300);
      check("t6_done_pulses", 32'(n_done - d0), 32'd1);
      check("t6_err_pulses", 32'(n_err - e0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the counterpart of the existing keyboard scancode receiver on the same open-drain clock/data pair.
- Sends command bytes to the keyboard, e.g. 0xED LED set, 0xFF reset, 0xF4 enable, so the core can drive lock LEDs and reset the keyboard.
- Sits in the top level beside the keyboard receiver. The top level combines the *_oe_o outputs into the tri-state pad drivers. The receiver ignores bus activity while busy_o is high.

Parameters:
- INHIBIT_CYC, 2400: clk_i cycles the host holds PS/2 clock low before request-to-send (100 us at 24 MHz).
- TIMEOUT_CYC, 360000: maximum clk_i cycles from clock release to ack (15 ms at 24 MHz).
- FILTER_CYC, 8: number of consecutive stable samples required before a synchronized PS/2 clock level is accepted.

Ports:
- clk_i, in, 1: system clock (24 MHz).
- res_n_i, in, 1: asynchronous active-low reset.
- data_i, in, 8: byte to send; sampled on the cycle start_i is accepted.
- start_i, in, 1: single-cycle request; accepted only in IDLE.
- busy_o, out, 1: high from accept until return to IDLE.
- done_o, out, 1: one-cycle pulse when the device ack is received.
- error_o, out, 1: one-cycle pulse on missing ack or timeout.
- ps2_clk_i, in, 1: PS/2 clock pad level (asynchronous).
- ps2_dat_i, in, 1: PS/2 data pad level (asynchronous).
- ps2_clk_oe_o, out, 1: 1 = pull PS/2 clock low; 0 = release the line.
- ps2_dat_oe_o, out, 1: 1 = pull PS/2 data low; 0 = release the line.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Reset asserted mid-transfer releases both lines immediately, asynchronously.
- Input conditioning:
  - ps2_clk_i and ps2_dat_i each pass through a 2-flop synchronizer.
  - The clock then passes through the FILTER_CYC stability filter.
  - A falling edge ("fe") is a filtered 1->0 transition, one cycle wide.
- Frame: shift register {stop=1, parity=~^data_i, data_i[7:0]}, sent LSB first. The bit counter counts 0..10.
- IDLE:
  - Lines are released.
  - start_i=1 latches the frame, sets busy_o, clears the counters and moves to INHIBIT.
  - start_i asserted while busy is ignored, with no queueing.
- INHIBIT:
  - clk_oe=1, dat_oe=0.
  - After INHIBIT_CYC cycles, assert dat_oe=1 (start bit) and move to RTS.
- RTS:
  - Hold dat_oe=1 for one cycle with clk_oe still 1.
  - Then release clock (clk_oe=0) and move to DATA.
  - Clear the timeout counter and start it.
- DATA: on each fe, drive dat_oe = ~frame[0] and shift; the device samples on the next rising edge.
  - fe #1..#8 output data bits 0..7.
  - fe #9 outputs the parity bit.
  - fe #10 outputs the stop bit (dat_oe=0) and moves to ACK.
- ACK:
  - On the next fe, sample the synchronized data line.
  - 0 means ack received; move to WAIT_IDLE.
  - 1 means no ack; pulse error_o and move to IDLE.
- WAIT_IDLE:
  - Wait for the filtered clock and synchronized data to both be high.
  - Then pulse done_o, clear busy_o and move to IDLE.
- Timeout:
  - Runs in DATA, ACK and WAIT_IDLE.
  - When the count reaches TIMEOUT_CYC: release both lines, pulse error_o, go to IDLE, clear busy_o.
  - Timeout takes priority over a simultaneous fe.
- done_o and error_o are mutually exclusive. busy_o falls in the same cycle as either pulse.
- The device pulling clock low before INHIBIT_CYC expires has no effect; the host keeps it inhibited.
- Counter widths are $clog2 of the respective parameter plus 1 and saturate, never wrap.

Decomposition:
- ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE;
  - the frame-length constant of 10 shifted bits;
  - the odd-parity function.
- One sub-module, ps2_sync_edge: 2-flop synchronizer, FILTER_CYC stability filter and falling-edge pulse, instantiated for the clock line. The data line uses only the synchronizer.

Test Plan:
1. Send 0xED with a device model that clocks at 12 kHz and acks. Check:
   - clock is held low for 2400 cycles;
   - data bits sampled on rising edges read 1,0,1,1,0,1,1,1, then parity 1, then stop 1;
   - done_o pulses once and busy_o drops.
2. Send 0x07 (parity 0) and then 0x00 (parity 1) back to back. Check:
   - parity bits are 0 and 1 respectively;
   - a start_i pulsed during the first transfer is ignored, so exactly two frames appear.
3. Device model holds data high at the 11th fe. Check that error_o pulses, done_o stays 0 and both oe outputs are 0.
4. Device never clocks, with TIMEOUT_CYC overridden to 1000. Check that error_o pulses exactly 1000 cycles after clock release and both lines are released.
5. Assert res_n_i low during DATA bit 4. Check:
   - ps2_clk_oe_o and ps2_dat_oe_o go to 0 without a clk_i edge;
   - after release, a new 0xFF transfer completes normally.
6. Inject 3-cycle glitches on ps2_clk_i during DATA. Check that no extra bit shifts occur and the received byte is unchanged.
